// File: rtl/store_queue_if.sv
// Store-queue bus bundle: pipeline store request side, data-memory write port and queue status.
interface store_queue_if #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_BITS = 32
);
  localparam int unsigned DATA_BITS = 32;
  localparam int unsigned BE_BITS   = DATA_BITS / 8;
  localparam int unsigned CNT_BITS  = $clog2(DEPTH) + 1;

  logic                 st_valid;
  logic                 st_ready;
  logic [ADDR_BITS-1:0] st_addr;
  logic [DATA_BITS-1:0] st_data;
  logic [2:0]           st_funct3;
  logic                 st_err;
  logic [ADDR_BITS-1:0] st_err_addr;

  logic                 mem_req;
  logic                 mem_gnt;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic [BE_BITS-1:0]   mem_be;

  logic                 q_empty;
  logic [CNT_BITS-1:0]  q_count;

  modport slave (
    input  st_valid, st_addr, st_data, st_funct3, mem_gnt,
    output st_ready, st_err, st_err_addr,
           mem_req, mem_addr, mem_wdata, mem_be,
           q_empty, q_count
  );

  modport master (
    output st_valid, st_addr, st_data, st_funct3, mem_gnt,
    input  st_ready, st_err, st_err_addr,
           mem_req, mem_addr, mem_wdata, mem_be,
           q_empty, q_count
  );
endinterface

// File: rtl/store_queue.sv
// In-order store buffer: formats committed stores onto byte lanes, rejects misaligned or
// illegal requests, and drains entries to the data-memory port over a req/gnt handshake.
module store_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_BITS = 32
) (
  input logic          clk,
  input logic          rst,
  store_queue_if.slave sq
);
  localparam int unsigned DATA_BITS = 32;
  localparam int unsigned BE_BITS   = DATA_BITS / 8;
  localparam int unsigned PTR_BITS  = $clog2(DEPTH);
  localparam int unsigned CNT_BITS  = PTR_BITS + 1;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
    logic [BE_BITS-1:0]   be;
  } entry_t;

  entry_t               entries_q [DEPTH];
  entry_t               entries_d [DEPTH];
  logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0]  count_q, count_d;
  logic                 empty_q, empty_d;
  logic                 st_ready_q, st_ready_d;
  logic                 mem_req_q, mem_req_d;
  logic                 st_err_q, st_err_d;
  logic [ADDR_BITS-1:0] st_err_addr_q, st_err_addr_d;

  entry_t               fmt_entry;
  logic                 fmt_legal;
  logic [1:0]           offset;
  logic                 accept;
  logic                 push;
  logic                 pop;

  // Lane replication and byte-enable generation for the incoming store.
  always_comb begin
    fmt_entry      = '0;
    fmt_legal      = 1'b0;
    offset         = sq.st_addr[1:0];
    fmt_entry.addr = {sq.st_addr[ADDR_BITS-1:2], 2'b00};
    case (sq.st_funct3)
      3'b000: begin
        fmt_legal       = 1'b1;
        fmt_entry.be    = BE_BITS'(4'b0001 << offset);
        fmt_entry.wdata = {4{sq.st_data[7:0]}};
      end
      3'b001: begin
        fmt_legal       = ~offset[0];
        fmt_entry.be    = BE_BITS'(4'b0011 << offset);
        fmt_entry.wdata = {2{sq.st_data[15:0]}};
      end
      3'b010: begin
        fmt_legal       = (offset == 2'b00);
        fmt_entry.be    = BE_BITS'(4'b1111);
        fmt_entry.wdata = sq.st_data;
      end
      default: begin
        fmt_legal = 1'b0;
      end
    endcase
  end

  // Rejected requests are still consumed; only legal ones occupy an entry.
  always_comb begin
    accept = sq.st_valid & st_ready_q;
    push   = accept & fmt_legal;
    pop    = mem_req_q & sq.mem_gnt;
  end

  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (push) begin
      entries_d[wr_ptr_q] = fmt_entry;
      wr_ptr_d            = wr_ptr_q + PTR_BITS'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_BITS'(1);
      2'b01:   count_d = count_q - CNT_BITS'(1);
      default: count_d = count_q;
    endcase

    // Status flags are registered copies of the post-edge occupancy.
    empty_d    = (count_d == CNT_BITS'(0));
    mem_req_d  = (count_d != CNT_BITS'(0));
    st_ready_d = (count_d != CNT_BITS'(DEPTH));
  end

  always_comb begin
    st_err_d      = accept & ~fmt_legal;
    st_err_addr_d = st_err_addr_q;
    if (accept && !fmt_legal) begin
      st_err_addr_d = sq.st_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      empty_q       <= 1'b1;
      mem_req_q     <= 1'b0;
      st_ready_q    <= 1'b1;
      st_err_q      <= 1'b0;
      st_err_addr_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      empty_q       <= empty_d;
      mem_req_q     <= mem_req_d;
      st_ready_q    <= st_ready_d;
      st_err_q      <= st_err_d;
      st_err_addr_q <= st_err_addr_d;
    end
  end

  // Head entry drives the memory port; it cannot change until popped.
  assign sq.mem_req     = mem_req_q;
  assign sq.mem_addr    = entries_q[rd_ptr_q].addr;
  assign sq.mem_wdata   = entries_q[rd_ptr_q].wdata;
  assign sq.mem_be      = entries_q[rd_ptr_q].be;
  assign sq.st_ready    = st_ready_q;
  assign sq.st_err      = st_err_q;
  assign sq.st_err_addr = st_err_addr_q;
  assign sq.q_empty     = empty_q;
  assign sq.q_count     = count_q;
endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: expected memory writes are queued as stores are driven
// and compared when the memory handshake completes.
module tb_store_queue;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } wr_t;

  logic clk;
  logic rst;
  int   n_asserts;
  int   n_fail;
  wr_t  sb[$];

  logic        pend;
  logic [31:0] hold_addr;
  logic [31:0] hold_wdata;
  logic [3:0]  hold_be;

  store_queue_if #(.DEPTH(4), .ADDR_BITS(32)) bus ();

  store_queue #(.DEPTH(4), .ADDR_BITS(32)) dut (
    .clk (clk),
    .rst (rst),
    .sq  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    wr_t w;
    w.addr  = a;
    w.wdata = d;
    w.be    = b;
    sb.push_back(w);
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    bus.st_valid  = v;
    bus.st_addr   = a;
    bus.st_data   = d;
    bus.st_funct3 = f3;
  endtask

  // Sample point: stall stability, then scoreboard compare on a completing handshake.
  task automatic sample();
    wr_t w;
    @(negedge clk);
    if (pend) begin
      chk("hold_req",   64'(bus.mem_req),   64'(1'b1));
      chk("hold_addr",  64'(bus.mem_addr),  64'(hold_addr));
      chk("hold_wdata", 64'(bus.mem_wdata), 64'(hold_wdata));
      chk("hold_be",    64'(bus.mem_be),    64'(hold_be));
    end
    pend = 1'b0;
    if (bus.mem_req === 1'b1 && bus.mem_gnt === 1'b1) begin
      chk("write_expected", 64'(sb.size() != 0), 64'(1'b1));
      if (sb.size() != 0) begin
        w = sb.pop_front();
        chk("wr_addr",  64'(bus.mem_addr),  64'(w.addr));
        chk("wr_wdata", 64'(bus.mem_wdata), 64'(w.wdata));
        chk("wr_be",    64'(bus.mem_be),    64'(w.be));
      end
    end else if (bus.mem_req === 1'b1) begin
      pend       = 1'b1;
      hold_addr  = bus.mem_addr;
      hold_wdata = bus.mem_wdata;
      hold_be    = bus.mem_be;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    pend      = 1'b0;
    rst       = 1'b1;
    bus.mem_gnt = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 3'b000);

    // Reset state
    sample();
    chk("rst_mem_req",     64'(bus.mem_req),     64'(0));
    chk("rst_st_err",      64'(bus.st_err),      64'(0));
    chk("rst_st_err_addr", 64'(bus.st_err_addr), 64'(0));
    chk("rst_q_count",     64'(bus.q_count),     64'(0));
    chk("rst_q_empty",     64'(bus.q_empty),     64'(1));
    chk("rst_mem_addr",    64'(bus.mem_addr),    64'(0));
    chk("rst_mem_wdata",   64'(bus.mem_wdata),   64'(0));
    chk("rst_mem_be",      64'(bus.mem_be),      64'(0));
    advance();
    rst = 1'b0;
    sample();
    chk("post_rst_ready", 64'(bus.st_ready), 64'(1));
    advance();

    // Single word store with grant tied high
    bus.mem_gnt = 1'b1;
    drive(1'b1, 32'h100, 32'hDEADBEEF, 3'b010);
    expect_wr(32'h100, 32'hDEADBEEF, 4'b1111);
    sample();
    chk("sw_no_req_yet", 64'(bus.mem_req), 64'(0));
    advance();
    drive(1'b0, 32'h0, 32'h0, 3'b000);
    sample();
    chk("sw_req", 64'(bus.mem_req), 64'(1));
    chk("sw_count", 64'(bus.q_count), 64'(1));
    advance();
    sample();
    chk("sw_empty", 64'(bus.q_empty), 64'(1));
    advance();

    // Byte then half into the same word, in order
    drive(1'b1, 32'h203, 32'h000000A5, 3'b000);
    expect_wr(32'h200, 32'hA5A5A5A5, 4'b1000);
    sample();
    advance();
    drive(1'b1, 32'h202, 32'h00001234, 3'b001);
    expect_wr(32'h200, 32'h12341234, 4'b1100);
    sample();
    advance();
    drive(1'b0, 32'h0, 32'h0, 3'b000);
    sample();
    advance();
    sample();
    chk("sbsh_empty", 64'(bus.q_empty), 64'(1));
    chk("sbsh_sb_drained", 64'(sb.size()), 64'(0));
    advance();

    // Back-to-back rejections: misaligned SW, illegal funct3
    drive(1'b1, 32'h102, 32'h11111111, 3'b010);
    sample();
    chk("rej1_err_before", 64'(bus.st_err), 64'(0));
    advance();
    drive(1'b1, 32'h304, 32'h22222222, 3'b011);
    sample();
    chk("rej1_err",      64'(bus.st_err),      64'(1));
    chk("rej1_err_addr", 64'(bus.st_err_addr), 64'(32'h102));
    chk("rej1_count",    64'(bus.q_count),     64'(0));
    chk("rej1_no_req",   64'(bus.mem_req),     64'(0));
    advance();
    drive(1'b0, 32'h0, 32'h0, 3'b000);
    sample();
    chk("rej2_err",      64'(bus.st_err),      64'(1));
    chk("rej2_err_addr", 64'(bus.st_err_addr), 64'(32'h304));
    chk("rej2_empty",    64'(bus.q_empty),     64'(1));
    advance();
    sample();
    chk("rej_err_clear", 64'(bus.st_err),      64'(0));
    chk("rej_addr_hold", 64'(bus.st_err_addr), 64'(32'h304));
    chk("rej_no_req",    64'(bus.mem_req),     64'(0));
    advance();

    // Stalled memory: fill to capacity, fifth store held off
    bus.mem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h400 + 32'(4 * i), 32'h10000000 + 32'(i), 3'b010);
      expect_wr(32'h400 + 32'(4 * i), 32'h10000000 + 32'(i), 4'b1111);
      sample();
      chk($sformatf("fill_ready_%0d", i), 64'(bus.st_ready), 64'(i < 4));
      if (i < 4) advance();
    end
    advance();
    sample();
    chk("full_count", 64'(bus.q_count),  64'(4));
    chk("full_ready", 64'(bus.st_ready), 64'(0));
    chk("full_req",   64'(bus.mem_req),  64'(1));
    advance();

    // Grant and valid in the same full cycle: pop only
    bus.mem_gnt = 1'b1;
    sample();
    chk("pop_full_count", 64'(bus.q_count),  64'(4));
    chk("pop_full_ready", 64'(bus.st_ready), 64'(0));
    advance();
    bus.mem_gnt = 1'b0;
    sample();
    chk("after_pop_count", 64'(bus.q_count),  64'(3));
    chk("after_pop_ready", 64'(bus.st_ready), 64'(1));
    advance();
    drive(1'b0, 32'h0, 32'h0, 3'b000);
    sample();
    chk("refill_count", 64'(bus.q_count),  64'(4));
    chk("refill_ready", 64'(bus.st_ready), 64'(0));
    advance();

    // Drain remaining entries in order
    bus.mem_gnt = 1'b1;
    for (int k = 0; k < 20 && bus.q_empty !== 1'b1; k++) begin
      sample();
      advance();
    end
    sample();
    chk("drain_empty", 64'(bus.q_empty), 64'(1));
    chk("drain_sb",    64'(sb.size()),   64'(0));
    advance();

    // Reset while a write is stalled with three entries queued
    bus.mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h600 + 32'(4 * i), 32'h0BAD0000 + 32'(i), 3'b010);
      sample();
      advance();
    end
    drive(1'b0, 32'h0, 32'h0, 3'b000);
    sample();
    chk("pre_rst_count", 64'(bus.q_count), 64'(3));
    chk("pre_rst_req",   64'(bus.mem_req), 64'(1));
    #1;
    rst  = 1'b1;
    pend = 1'b0;
    #1;
    chk("async_rst_req",   64'(bus.mem_req), 64'(0));
    chk("async_rst_count", 64'(bus.q_count), 64'(0));
    chk("async_rst_empty", 64'(bus.q_empty), 64'(1));
    advance();
    rst = 1'b0;
    bus.mem_gnt = 1'b1;
    drive(1'b1, 32'h500, 32'hCAFEF00D, 3'b010);
    expect_wr(32'h500, 32'hCAFEF00D, 4'b1111);
    sample();
    advance();
    drive(1'b0, 32'h0, 32'h0, 3'b000);
    sample();
    chk("post_rst_req", 64'(bus.mem_req), 64'(1));
    advance();
    sample();
    chk("post_rst_sb",    64'(sb.size()),   64'(0));
    chk("post_rst_empty", 64'(bus.q_empty), 64'(1));
    advance();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
